// File: rtl/winograd_pkg.sv
// Shared constants and the scheduler state encoding for the Winograd F(4x4,3x3) tile scheduler.
package winograd_pkg;

  localparam int TILE_IN     = 6;
  localparam int TILE_OUT    = 4;
  localparam int TILE_STRIDE = 4;
  localparam int KERNEL      = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_ERR,
    S_FETCH,
    S_DRAIN,
    S_LAUNCH,
    S_WAIT_TC,
    S_WRITE,
    S_NEXT,
    S_FIN
  } sched_state_t;

endpackage

// File: rtl/winograd_tile_addr_gen.sv
// Combinational pixel locator: in input mode it bounds-checks a 6x6 tap against the image, in output
// mode it bounds-checks a 4x4 result position against the (rows-2)x(cols-2) output.
module winograd_tile_addr_gen
  import winograd_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              out_mode,
  input  logic [7:0]        base_row,
  input  logic [7:0]        base_col,
  input  logic [2:0]        off_i,
  input  logic [2:0]        off_j,
  input  logic [7:0]        rows,
  input  logic [7:0]        cols,
  output logic              valid,
  output logic [ADDR_W-1:0] addr
);

  logic [8:0] row;
  logic [8:0] col;
  logic [8:0] lim_r;
  logic [8:0] lim_c;

  always_comb begin
    row   = {1'b0, base_row} + {6'd0, off_i};
    col   = {1'b0, base_col} + {6'd0, off_j};
    // The output image is narrower by KERNEL-1, and its width is also the row pitch.
    lim_r = out_mode ? ({1'b0, rows} - 9'(KERNEL - 1)) : {1'b0, rows};
    lim_c = out_mode ? ({1'b0, cols} - 9'(KERNEL - 1)) : {1'b0, cols};
    valid = (row < lim_r) && (col < lim_c);
    addr  = ADDR_W'(row) * ADDR_W'(lim_c) + ADDR_W'(col);
  end

endmodule

// File: rtl/winograd_tile_scheduler.sv
// Walks 6x6 input tiles at stride 4 over a single-channel image, feeds each one to a tile_controller
// and scatters the 4x4 results into the valid output region.
module winograd_tile_scheduler
  import winograd_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MAX_DIM = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_rows,
  input  logic [7:0]        in_cols,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [DATA_W-1:0] src_rd_data,
  output logic              tc_start,
  output logic [DATA_W-1:0] tc_tile [0:5][0:5],
  input  logic              tc_done,
  input  logic [DATA_W-1:0] tc_result [0:3][0:3],
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_wr_addr,
  output logic [DATA_W-1:0] dst_wr_data,
  output sched_state_t      dbg_state
);

  sched_state_t state_q, state_d;

  logic [7:0]        rows_q, cols_q;
  logic [5:0]        tile_r, tile_c;
  logic [5:0]        tr_last, tc_last;
  logic [8:0]        tr_num, tc_num;
  logic [2:0]        idx_i, idx_j, idx_max;
  logic              pend_v, pend_inb;
  logic [2:0]        pend_i, pend_j;
  logic [DATA_W-1:0] res [0:3][0:3];
  logic              dims_ok, last_idx, last_tile;
  logic              ag_valid;
  logic [ADDR_W-1:0] ag_addr;

  assign dbg_state = state_q;

  always_comb begin
    tr_num    = ({1'b0, rows_q} - 9'(KERNEL - 1) + 9'(TILE_STRIDE - 1)) / 9'(TILE_STRIDE);
    tc_num    = ({1'b0, cols_q} - 9'(KERNEL - 1) + 9'(TILE_STRIDE - 1)) / 9'(TILE_STRIDE);
    tr_last   = 6'(tr_num - 9'd1);
    tc_last   = 6'(tc_num - 9'd1);
    dims_ok   = (rows_q >= 8'(KERNEL)) && ({1'b0, rows_q} <= 9'(MAX_DIM)) &&
                (cols_q >= 8'(KERNEL)) && ({1'b0, cols_q} <= 9'(MAX_DIM));
    idx_max   = (state_q == S_WRITE) ? 3'(TILE_OUT - 1) : 3'(TILE_IN - 1);
    last_idx  = (idx_i == idx_max) && (idx_j == idx_max);
    last_tile = (tile_r == tr_last) && (tile_c == tc_last);
  end

  winograd_tile_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .out_mode (state_q == S_WRITE),
    .base_row ({tile_r, 2'b00}),
    .base_col ({tile_c, 2'b00}),
    .off_i    (idx_i),
    .off_j    (idx_j),
    .rows     (rows_q),
    .cols     (cols_q),
    .valid    (ag_valid),
    .addr     (ag_addr)
  );

  // Handshakes: src_rd_en is a fire-and-forget strobe whose data returns exactly one cycle later;
  // tc_start is a one-cycle pulse, tc_tile is frozen until tc_done, and tc_done is only honoured in WAIT_TC.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    src_rd_en   = 1'b0;
    src_rd_addr = '0;
    tc_start    = 1'b0;
    dst_wr_en   = 1'b0;
    dst_wr_addr = '0;
    dst_wr_data = '0;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CHECK;
      S_CHECK: begin
        busy    = 1'b1;
        state_d = dims_ok ? S_FETCH : S_ERR;
      end
      S_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = S_IDLE;
      end
      S_FETCH: begin
        busy        = 1'b1;
        src_rd_en   = ag_valid;
        src_rd_addr = ag_valid ? ag_addr : '0;
        if (last_idx) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        busy     = 1'b1;
        tc_start = 1'b1;
        state_d  = S_WAIT_TC;
      end
      S_WAIT_TC: begin
        busy = 1'b1;
        if (tc_done) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        dst_wr_en   = ag_valid;
        dst_wr_addr = ag_valid ? ag_addr : '0;
        dst_wr_data = ag_valid ? res[idx_i[1:0]][idx_j[1:0]] : '0;
        if (last_idx) state_d = S_NEXT;
      end
      S_NEXT: begin
        busy    = 1'b1;
        state_d = last_tile ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      tile_r   <= '0;
      tile_c   <= '0;
      idx_i    <= '0;
      idx_j    <= '0;
      pend_v   <= 1'b0;
      pend_inb <= 1'b0;
      pend_i   <= '0;
      pend_j   <= '0;
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) tc_tile[i][j] <= '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) res[i][j] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        rows_q <= in_rows;
        cols_q <= in_cols;
        tile_r <= '0;
        tile_c <= '0;
      end
      // One shared row-major index walks taps in FETCH and result positions in WRITE.
      if (state_q == S_FETCH || state_q == S_WRITE) begin
        if (idx_j == idx_max) begin
          idx_j <= '0;
          idx_i <= (idx_i == idx_max) ? 3'd0 : idx_i + 3'd1;
        end else begin
          idx_j <= idx_j + 3'd1;
        end
      end else begin
        idx_i <= '0;
        idx_j <= '0;
      end
      pend_v   <= (state_q == S_FETCH);
      pend_inb <= ag_valid;
      pend_i   <= idx_i;
      pend_j   <= idx_j;
      if (pend_v) tc_tile[pend_i][pend_j] <= pend_inb ? src_rd_data : '0;
      if (state_q == S_WAIT_TC && tc_done) begin
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) res[i][j] <= tc_result[i][j];
      end
      if (state_q == S_NEXT) begin
        if (tile_c == tc_last) begin
          tile_c <= '0;
          tile_r <= tile_r + 6'd1;
        end else begin
          tile_c <= tile_c + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_winograd_tile_scheduler.sv
// Bench for winograd_tile_scheduler: ramp source RAM, fixed-latency tile_controller model, write scoreboard.
module tb_winograd_tile_scheduler;
  import winograd_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int TC_LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_rows = '0;
  logic [7:0]        in_cols = '0;
  logic              busy, done, err;
  logic              src_rd_en;
  logic [ADDR_W-1:0] src_rd_addr;
  logic [DATA_W-1:0] src_rd_data = '0;
  logic              tc_start;
  logic [DATA_W-1:0] tc_tile [0:5][0:5];
  logic              tc_done = 1'b0;
  logic [DATA_W-1:0] tc_result [0:3][0:3];
  logic              dst_wr_en;
  logic [ADDR_W-1:0] dst_wr_addr;
  logic [DATA_W-1:0] dst_wr_data;
  sched_state_t      dbg_state;

  winograd_tile_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_DIM(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_rows(in_rows), .in_cols(in_cols),
    .busy(busy), .done(done), .err(err),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .tc_start(tc_start), .tc_tile(tc_tile), .tc_done(tc_done), .tc_result(tc_result),
    .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard state
  logic [31:0]       exp_q[$];
  int                n_rd, n_wr, n_tiles, n_done, n_errp, tile_idx;
  int                cur_rows = 6, cur_cols = 6;
  bit                inject = 1'b0;
  logic              last_en = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] snap [0:5][0:5];
  int                tc_cnt = 0;
  int                br, bc, bad, orow, ocol, ev;
  logic [31:0]       e;

  // source RAM (pixel = address) and tile_controller models plus output monitor
  always @(negedge clk) begin
    src_rd_data = last_en ? last_addr : 16'hDEAD;
    last_en     = src_rd_en;
    last_addr   = src_rd_addr;
    if (src_rd_en) begin
      n_rd++;
      check("rd_addr_range", 32'(int'(src_rd_addr) < cur_rows * cur_cols), 1);
    end
    tc_done = 1'b0;
    if (tc_start) begin
      n_tiles++;
      br = 4 * (tile_idx / ((cur_cols + 1) / 4));
      bc = 4 * (tile_idx % ((cur_cols + 1) / 4));
      tile_idx++;
      bad = 0;
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) begin
          ev = (br + i < cur_rows && bc + j < cur_cols) ? (br + i) * cur_cols + bc + j : 0;
          if (tc_tile[i][j] !== 16'(ev)) bad++;
          snap[i][j] = tc_tile[i][j];
        end
      check("tile_content", bad, 0);
      for (int p = 0; p < 16; p++) begin
        orow = br + p / 4;
        ocol = bc + p % 4;
        if (orow < cur_rows - 2 && ocol < cur_cols - 2)
          exp_q.push_back({16'(orow * (cur_cols - 2) + ocol),
                           16'((orow + 1) * cur_cols + ocol + 1 + 1000)});
      end
      tc_cnt = TC_LAT;
    end else if (tc_cnt > 0) begin
      tc_cnt--;
      if (tc_cnt == 0) begin
        bad = 0;
        for (int i = 0; i < 6; i++)
          for (int j = 0; j < 6; j++) if (tc_tile[i][j] !== snap[i][j]) bad++;
        check("tile_stable", bad, 0);
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 4; b++) tc_result[a][b] = snap[a + 1][b + 1] + 16'd1000;
        tc_done = 1'b1;
      end
    end
    if (inject && dbg_state == S_FETCH) begin
      inject  = 1'b0;
      tc_done = 1'b1;
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) tc_result[a][b] = 16'hBEEF;
    end
    if (dst_wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", dst_wr_addr, e[31:16]);
        check("wr_data", dst_wr_data, e[15:0]);
      end
    end
    if (done) n_done++;
    if (err) n_errp++;
  end

  // driver
  task automatic run_job(input int r, input int c, input bit extra_start, input bit inj,
                         output int cycles);
    @(negedge clk);
    n_rd = 0; n_wr = 0; n_tiles = 0; n_done = 0; n_errp = 0; tile_idx = 0;
    exp_q.delete();
    cur_rows = r; cur_cols = c;
    in_rows = 8'(r); in_cols = 8'(c); start = 1'b1; inject = inj;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cycles = 0;
    while (!done && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (extra_start && (cycles == 10 || cycles == 45)) begin
        start = 1'b1; in_rows = 8'd3; in_cols = 8'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    repeat (2) @(negedge clk);
    check("done_pulses", n_done, 1);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    int rows, cols, reads, tiles, writes, err, cycles;
  } vec_t;

  vec_t vecs [9];
  int   cyc;
  int   nz;

  initial begin
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) tc_result[a][b] = '0;

    vecs[0] = '{6,   6,   36,  1,  16,  0, 59};
    vecs[1] = '{3,   3,   9,   1,  1,   0, 59};
    vecs[2] = '{10,  7,   108, 4,  40,  0, 233};
    vecs[3] = '{7,   11,  135, 6,  45,  0, 349};
    vecs[4] = '{128, 3,   570, 32, 126, 0, 1857};
    vecs[5] = '{2,   6,   0,   0,  0,   1, 1};
    vecs[6] = '{6,   200, 0,   0,  0,   1, 1};
    vecs[7] = '{129, 5,   0,   0,  0,   1, 1};
    vecs[8] = '{0,   9,   0,   0,  0,   1, 1};

    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_src_rd_en", src_rd_en, 0);
    check("rst_tc_start", tc_start, 0);
    check("rst_dst_wr_en", dst_wr_en, 0);
    check("rst_state", dbg_state, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[v]) begin
      run_job(vecs[v].rows, vecs[v].cols, 1'b0, 1'b0, cyc);
      check($sformatf("v%0d_cycles", v), cyc, vecs[v].cycles);
      check($sformatf("v%0d_reads", v), n_rd, vecs[v].reads);
      check($sformatf("v%0d_tiles", v), n_tiles, vecs[v].tiles);
      check($sformatf("v%0d_writes", v), n_wr, vecs[v].writes);
      check($sformatf("v%0d_err", v), n_errp, vecs[v].err);
    end

    // reset asserted at FETCH tap 20 of a 6x6 job
    @(negedge clk);
    cur_rows = 6; cur_cols = 6; tile_idx = 0; exp_q.delete();
    in_rows = 8'd6; in_cols = 8'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10 && dbg_state != S_FETCH; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("tap20_rd_en", src_rd_en, 1);
    check("tap20_addr", src_rd_addr, 20);
    rst_n = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) if (tc_tile[i][j] !== '0) nz++;
    check("mid_rst_outputs", {busy, done, err, src_rd_en, tc_start, dst_wr_en}, 0);
    check("mid_rst_addrs", {src_rd_addr, dst_wr_addr}, 0);
    check("mid_rst_data", dst_wr_data, 0);
    check("mid_rst_tile", nz, 0);
    check("mid_rst_state", dbg_state, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(6, 6, 1'b0, 1'b0, cyc);
    check("post_rst_cycles", cyc, 59);
    check("post_rst_reads", n_rd, 36);
    check("post_rst_writes", n_wr, 16);

    // start pulses while busy and a spurious tc_done during FETCH
    run_job(6, 6, 1'b1, 1'b1, cyc);
    check("ign_cycles", cyc, 59);
    check("ign_reads", n_rd, 36);
    check("ign_tiles", n_tiles, 1);
    check("ign_writes", n_wr, 16);
    check("ign_err", n_errp, 0);
    check("ign_inject_used", inject, 0);
    repeat (3) @(negedge clk);
    check("ign_idle_after", dbg_state, S_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
